masked_gf16_mul_pini_pipe: RTL
==============================

Name: masked_gf16_mul_pini_pipe

Overview:
- Parametrised, multi-lane, first-order PINI two-share masked GF(2^4) multiplier.
- Successor of the single-lane fixed-latency gadget. Adds a lane count, an optional output register stage, valid/ready flow control with back-pressure, and a randomness-valid qualifier.
- Sits in the masked S-box datapath between the shared affine/linear layers and the GF(16) inversion stages.

Parameters:
- LANES, 1: number of independent GF(16) multiplications per transaction.
- OUT_REG, 0: 0 = outputs combinational from the stage-1 registers (latency 1); 1 = extra output register (latency 2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand shares present.
- in_ready  out  1  block can accept a transaction this cycle.
- a0  in  4*LANES  share 0 of operand a; lane i occupies bits [4i+3:4i].
- a1  in  4*LANES  share 1 of operand a.
- b0  in  4*LANES  share 0 of operand b.
- b1  in  4*LANES  share 1 of operand b.
- rnd  in  8*LANES  fresh randomness; per lane {s[3:0], r[3:0]} at bits [8i+7:8i].
- rnd_valid  in  1  rnd is fresh this cycle.
- out_valid  out  1  q shares valid.
- out_ready  in  1  consumer accepts q.
- q0  out  4*LANES  share 0 of a·b.
- q1  out  4*LANES  share 1 of a·b.

Behaviour:
- Field: GF(2^4), polynomial x^4+x+1, bit 0 = x^0. ⊗ denotes GF(16) multiply.
- Accept: fire = in_valid & rnd_valid & in_ready. If rnd_valid=0, nothing is accepted regardless of in_valid. Each accepted transaction requires fresh rnd; the block does not check freshness.
- Per lane, combinational before stage 1:
  - L0 = a0⊗(b0⊕r)⊕s
  - L1 = a1⊗(b1⊕r)⊕s
- Stage-1 registers per lane, loaded only on fire, otherwise hold bit-exact:
  - domain 0: A0=a0, M0=b1⊕r, L0
  - domain 1: A1=a1, M1=b0⊕r, L1
  - The cross-domain operand enters the other domain only via a register and only masked with r.
- After stage 1, per lane: q0 = A0⊗M0⊕L0 and q1 = A1⊗M1⊕L1. Then q0⊕q1 = a·b (s cancels, r cancels).
- Domain separation: no combinational path may mix domain-0 and domain-1 signals. Each domain's logic uses only its own shares and registered masked cross terms.
- OUT_REG=0:
  - out_valid = v1.
  - in_ready = !v1 | out_ready.
  - v1 sets on fire, clears when v1 & out_ready & !fire.
- OUT_REG=1:
  - Stage-2 registers Q0/Q1 load q0/q1 when v1 & (!v2 | out_ready).
  - out_valid = v2.
  - in_ready = !v1 | !v2 | out_ready.
  - Sustained throughput is one transaction per cycle when out_ready=1.
- Simultaneous accept and drain of the same stage: new data is loaded, valid stays 1.
- Outputs while out_valid=0: driven from held registers (deterministic, don't-care to the consumer). The stage-1 registers must never change without fire, to avoid glitch-driven leakage.
- Reset (asynchronous, any time including mid-transaction):
  - all valid bits and all data registers clear to 0 immediately;
  - out_valid=0, in_ready=1, q0=q1=0;
  - in-flight transactions are discarded.
- Lanes are fully independent and share only the valid/ready control.

Decomposition:
- Shared package:
  - GF16_POLY constant (4'h3, low terms of x^4+x+1)
  - gf16_mul function
  - lane width constants: 4 data bits, 8 random bits
- Sub-module masked_gf16_mul_lane: one lane's two domains plus stage-1 data registers with load enable. Instantiated LANES times by a generate loop.
- Top level holds only valid/ready control and the optional stage 2.

Test Plan:
- LANES=1, OUT_REG=0; a0=5, a1=7 (a=2); b0=9, b1=A (b=3); rnd=8'h3C; all handshakes high -> next cycle out_valid=1, q0⊕q1=6.
- Same config; (a,b)=(8,2) -> 3 and (F,F) -> A. For each, sweep all 256 rnd values with random share splits -> q0⊕q1 constant, and q0 alone changes with s.
- Back-pressure: fire once, then out_ready=0 for 3 cycles -> in_ready=0 while full, q0/q1 bit-stable, no second accept. Raise out_ready -> drained, in_ready=1 the same cycle.
- in_valid=1, rnd_valid=0 for 4 cycles -> no accept, out_valid stays 0. Then rnd_valid=1 -> accepted, result appears 1 cycle later.
- Reset mid-operation: fire, then drop rst_n between clock edges -> out_valid=0 and q0=q1=0 without waiting for a clock edge. After release, first result comes from a new transaction only.
- LANES=4, OUT_REG=1; 16 back-to-back transactions with random operands -> out_valid after 2 cycles, one result per cycle, every lane correct. Toggling out_ready at random loses and duplicates no transaction.

Source files
------------

// File: rtl/masked_gf16_mul_pini_pipe_pkg.sv
// masked_gf16_mul_pini_pipe_pkg: GF(2^4) field constants and multiply helper
package masked_gf16_mul_pini_pipe_pkg;
  localparam logic [3:0] GF16_POLY = 4'h3;
  localparam int DW = 4;
  localparam int RW = 8;
  function automatic logic [DW-1:0] gf16_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] p;
    logic [DW-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < DW; i++) begin
      p = p ^ (b[i] ? x : '0);
      x = x[DW-1] ? ({x[DW-2:0], 1'b0} ^ GF16_POLY) : {x[DW-2:0], 1'b0};
    end
    return p;
  endfunction
endpackage

// File: rtl/masked_gf16_mul_lane.sv
// masked_gf16_mul_lane: one lane's two share domains and stage-1 registers
module masked_gf16_mul_lane
  import masked_gf16_mul_pini_pipe_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b0,
  input  logic [DW-1:0] b1,
  input  logic [RW-1:0] rnd,
  output logic [DW-1:0] q0,
  output logic [DW-1:0] q1
);
  logic [DW-1:0] r, s;
  logic [DW-1:0] a0_q, m0_q, l0_q, a1_q, m1_q, l1_q;
  assign r = rnd[DW-1:0];
  assign s = rnd[RW-1:DW];
  // cross-domain operands only ever cross through a register, masked with r
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_q <= '0;
      m0_q <= '0;
      l0_q <= '0;
      a1_q <= '0;
      m1_q <= '0;
      l1_q <= '0;
    end else if (load) begin
      a0_q <= a0;
      m0_q <= b1 ^ r;
      l0_q <= gf16_mul(a0, b0 ^ r) ^ s;
      a1_q <= a1;
      m1_q <= b0 ^ r;
      l1_q <= gf16_mul(a1, b1 ^ r) ^ s;
    end
  end
  assign q0 = gf16_mul(a0_q, m0_q) ^ l0_q;
  assign q1 = gf16_mul(a1_q, m1_q) ^ l1_q;
endmodule

// File: rtl/masked_gf16_mul_pini_pipe.sv
// masked_gf16_mul_pini_pipe: multi-lane PINI masked GF(16) multiplier with
// valid/ready flow control and optional output register stage
module masked_gf16_mul_pini_pipe
  import masked_gf16_mul_pini_pipe_pkg::*;
#(
  parameter int LANES   = 1,
  parameter int OUT_REG = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW*LANES-1:0] a0,
  input  logic [DW*LANES-1:0] a1,
  input  logic [DW*LANES-1:0] b0,
  input  logic [DW*LANES-1:0] b1,
  input  logic [RW*LANES-1:0] rnd,
  input  logic                rnd_valid,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW*LANES-1:0] q0,
  output logic [DW*LANES-1:0] q1
);
  logic v1, v2, fire, adv;
  logic [DW*LANES-1:0] s1_q0, s1_q1;
  assign fire = in_valid & rnd_valid & in_ready;
  assign adv = v1 & ((OUT_REG != 0) ? (!v2 | out_ready) : out_ready);
  assign in_ready = !v1 | adv;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v1 <= 1'b0;
    else v1 <= fire | (v1 & !adv);
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    masked_gf16_mul_lane u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .load (fire),
      .a0   (a0[DW*i +: DW]),
      .a1   (a1[DW*i +: DW]),
      .b0   (b0[DW*i +: DW]),
      .b1   (b1[DW*i +: DW]),
      .rnd  (rnd[RW*i +: RW]),
      .q0   (s1_q0[DW*i +: DW]),
      .q1   (s1_q1[DW*i +: DW])
    );
  end
  if (OUT_REG != 0) begin : g_out_reg
    logic [DW*LANES-1:0] r0, r1;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2 <= 1'b0;
        r0 <= '0;
        r1 <= '0;
      end else if (adv) begin
        v2 <= 1'b1;
        r0 <= s1_q0;
        r1 <= s1_q1;
      end else if (out_ready) begin
        v2 <= 1'b0;
      end
    end
    assign out_valid = v2;
    assign q0 = r0;
    assign q1 = r1;
  end else begin : g_no_out_reg
    assign v2 = 1'b0;
    assign out_valid = v1;
    assign q0 = s1_q0;
    assign q1 = s1_q1;
  end
endmodule
